// File: rtl/cfs_apb_pkg.sv
// Shared types and constants for the CFS APB master.
// Holds the transfer state encoding and the data and wait-counter widths.
package cfs_apb_pkg;

  localparam int APB_DATA_WIDTH = 32;
  localparam int WAIT_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/cfs_apb_master.sv
// Single-outstanding APB master with request/response handshakes and an
// optional ACCESS-phase timeout. Every output is driven straight from a register.
module cfs_apb_master
  import cfs_apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic                      pready,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pslverr
);

  localparam logic [WAIT_CNT_WIDTH-1:0] TIMEOUT_LIMIT = WAIT_CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic                      TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_ZERO     = {APB_ADDR_WIDTH{1'b0}};
  localparam logic [APB_DATA_WIDTH-1:0] DATA_ZERO     = {APB_DATA_WIDTH{1'b0}};
  localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ZERO      = {WAIT_CNT_WIDTH{1'b0}};
  localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ONE       = {{(WAIT_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WAIT_CNT_WIDTH-1:0] CNT_MAX       = {WAIT_CNT_WIDTH{1'b1}};

  apb_state_e                state_r, state_s;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_r, wait_cnt_s, wait_inc_s;
  logic                      req_ready_r, req_ready_s;
  logic                      psel_r, psel_s, penable_r, penable_s;
  logic [APB_ADDR_WIDTH-1:0] paddr_r, paddr_s;
  logic                      pwrite_r, pwrite_s;
  logic [APB_DATA_WIDTH-1:0] pwdata_r, pwdata_s;
  logic                      rsp_valid_r, rsp_valid_s;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_s;
  logic                      rsp_slverr_r, rsp_slverr_s;
  logic                      rsp_timeout_r, rsp_timeout_s;

  // Next-state, captured command, response capture and registered output values
  always_comb begin
    state_s       = state_r;
    wait_cnt_s    = wait_cnt_r;
    paddr_s       = paddr_r;
    pwrite_s      = pwrite_r;
    pwdata_s      = pwdata_r;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_slverr_s  = rsp_slverr_r;
    rsp_timeout_s = rsp_timeout_r;
    // Saturate so a disabled timeout never lets the counter wrap
    wait_inc_s    = (wait_cnt_r == CNT_MAX) ? wait_cnt_r : (wait_cnt_r + CNT_ONE);

    case (state_r)
      IDLE: begin
        rsp_rdata_s   = DATA_ZERO;
        rsp_slverr_s  = 1'b0;
        rsp_timeout_s = 1'b0;
        if (req_valid && req_ready_r) begin
          state_s    = SETUP;
          paddr_s    = req_addr;
          pwrite_s   = req_write;
          pwdata_s   = req_wdata;
          wait_cnt_s = CNT_ZERO;
        end else begin
          paddr_s  = ADDR_ZERO;
          pwrite_s = 1'b0;
          pwdata_s = DATA_ZERO;
        end
      end
      SETUP: begin
        state_s = ACCESS;
      end
      ACCESS: begin
        // pready wins over the timeout when both land in the same cycle
        if (pready) begin
          state_s       = RESP;
          rsp_rdata_s   = pwrite_r ? DATA_ZERO : prdata;
          rsp_slverr_s  = pslverr;
          rsp_timeout_s = 1'b0;
          paddr_s       = ADDR_ZERO;
          pwrite_s      = 1'b0;
          pwdata_s      = DATA_ZERO;
        end else if (TIMEOUT_EN && (wait_inc_s == TIMEOUT_LIMIT)) begin
          state_s       = RESP;
          wait_cnt_s    = wait_inc_s;
          rsp_rdata_s   = DATA_ZERO;
          rsp_slverr_s  = 1'b1;
          rsp_timeout_s = 1'b1;
          paddr_s       = ADDR_ZERO;
          pwrite_s      = 1'b0;
          pwdata_s      = DATA_ZERO;
        end else begin
          wait_cnt_s = wait_inc_s;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    req_ready_s = (state_s == IDLE);
    psel_s      = (state_s == SETUP) || (state_s == ACCESS);
    penable_s   = (state_s == ACCESS);
    rsp_valid_s = (state_s == RESP);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_r       <= IDLE;
      wait_cnt_r    <= CNT_ZERO;
      req_ready_r   <= 1'b0;
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      paddr_r       <= ADDR_ZERO;
      pwrite_r      <= 1'b0;
      pwdata_r      <= DATA_ZERO;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= DATA_ZERO;
      rsp_slverr_r  <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      wait_cnt_r    <= wait_cnt_s;
      req_ready_r   <= req_ready_s;
      psel_r        <= psel_s;
      penable_r     <= penable_s;
      paddr_r       <= paddr_s;
      pwrite_r      <= pwrite_s;
      pwdata_r      <= pwdata_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_slverr_r  <= rsp_slverr_s;
      rsp_timeout_r <= rsp_timeout_s;
    end
  end

  assign req_ready   = req_ready_r;
  assign psel        = psel_r;
  assign penable     = penable_r;
  assign paddr       = paddr_r;
  assign pwrite      = pwrite_r;
  assign pwdata      = pwdata_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_slverr  = rsp_slverr_r;
  assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_cfs_apb_master.sv
// Directed self-checking bench for cfs_apb_master; the bench plays the APB
// slave and the command/response client with hand-computed expectations.
module tb_cfs_apb_master;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = 16'h0000;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [15:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'h0;
  logic        pslverr = 1'b0;

  int checks = 0;
  int errors = 0;

  cfs_apb_master #(.APB_ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Presents a command; returns one cycle after the handshake edge (SETUP cycle)
  task automatic issue(input logic [15:0] a, input logic w, input logic [31:0] d);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    tick(); tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    checks++; if ({psel, penable, pwrite, rsp_valid, rsp_slverr, rsp_timeout} !== 6'b0) begin errors++; $display("FAIL rst_ctrl: got %b expected 000000", {psel, penable, pwrite, rsp_valid, rsp_slverr, rsp_timeout}); end
    checks++; if ({paddr, pwdata, rsp_rdata} !== 80'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", {paddr, pwdata, rsp_rdata}); end
    presetn = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_write_wait();
    issue(16'h0000, 1'b1, 32'h0000_0101);
    checks++; if ({psel, penable, pwrite} !== 3'b101 || paddr !== 16'h0000 || pwdata !== 32'h0000_0101) begin errors++; $display("FAIL wr_setup: got sel/en/wr=%b addr=%h data=%h expected 101 0000 00000101", {psel, penable, pwrite}, paddr, pwdata); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wr_setup_ready: got %b expected 0", req_ready); end
    pready = 1'b1;
    tick();
    pready = 1'b0;
    checks++; if ({psel, penable, rsp_valid} !== 3'b110) begin errors++; $display("FAIL wr_access1: got sel/en/rv=%b expected 110", {psel, penable, rsp_valid}); end
    tick();
    checks++; if ({psel, penable, rsp_valid} !== 3'b110 || pwdata !== 32'h0000_0101 || pwrite !== 1'b1) begin errors++; $display("FAIL wr_access2: got sel/en/rv=%b data=%h expected 110 00000101", {psel, penable, rsp_valid}, pwdata); end
    pready = 1'b1; prdata = 32'hDEAD_BEEF;
    tick();
    pready = 1'b0;
    checks++; if ({rsp_valid, rsp_slverr, rsp_timeout, psel, penable} !== 5'b10000 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp: got v/e/t/sel/en=%b rdata=%h expected 10000 00000000", {rsp_valid, rsp_slverr, rsp_timeout, psel, penable}, rsp_rdata); end
    finish_rsp();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || paddr !== 16'h0 || pwdata !== 32'h0) begin errors++; $display("FAIL wr_idle: got ready=%b rv=%b addr=%h data=%h expected 1 0 0 0", req_ready, rsp_valid, paddr, pwdata); end
  endtask

  task automatic test_read_fast();
    issue(16'h000C, 1'b0, 32'h0);
    checks++; if ({psel, penable, pwrite} !== 3'b100 || paddr !== 16'h000C) begin errors++; $display("FAIL rd_setup: got sel/en/wr=%b addr=%h expected 100 000c", {psel, penable, pwrite}, paddr); end
    pready = 1'b1; prdata = 32'h0003_0205;
    tick();
    checks++; if ({psel, penable} !== 2'b11 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_access: got sel/en/rv=%b expected 110", {psel, penable, rsp_valid}); end
    tick();
    pready = 1'b0; prdata = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0003_0205 || rsp_slverr !== 1'b0) begin errors++; $display("FAIL rd_resp: got rv=%b rdata=%h err=%b expected 1 00030205 0", rsp_valid, rsp_rdata, rsp_slverr); end
    finish_rsp();
  endtask

  task automatic test_write_slverr();
    issue(16'h000C, 1'b1, 32'h1234_5678);
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
    tick(); tick();
    pready = 1'b0; pslverr = 1'b0;
    checks++; if ({rsp_valid, rsp_slverr, rsp_timeout} !== 3'b110 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL slverr_resp: got v/e/t=%b rdata=%h expected 110 00000000", {rsp_valid, rsp_slverr, rsp_timeout}, rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_timeout();
    int access_cnt;
    int guard;
    pready = 1'b0; prdata = 32'hA5A5_A5A5;
    issue(16'h0010, 1'b0, 32'h0);
    access_cnt = 0;
    guard = 0;
    tick();
    while (rsp_valid !== 1'b1 && guard < 40) begin
      if (penable === 1'b1) access_cnt++;
      tick();
      guard++;
    end
    checks++; if (access_cnt != 16) begin errors++; $display("FAIL to_access_cycles: got %0d expected 16", access_cnt); end
    checks++; if ({rsp_valid, rsp_timeout, rsp_slverr, psel, penable} !== 5'b11100 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_resp: got v/t/e/sel/en=%b rdata=%h expected 11100 00000000", {rsp_valid, rsp_timeout, rsp_slverr, psel, penable}, rsp_rdata); end
    finish_rsp();
    // pready arriving in the 16th ACCESS cycle completes normally
    issue(16'h0014, 1'b0, 32'h0);
    tick();
    for (int k = 1; k < 16; k++) tick();
    checks++; if ({psel, penable, rsp_valid} !== 3'b110) begin errors++; $display("FAIL edge_access16: got sel/en/rv=%b expected 110", {psel, penable, rsp_valid}); end
    pready = 1'b1; prdata = 32'h0BAD_F00D;
    tick();
    pready = 1'b0;
    checks++; if ({rsp_valid, rsp_timeout, rsp_slverr} !== 3'b100 || rsp_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL edge_resp: got v/t/e=%b rdata=%h expected 100 0badf00d", {rsp_valid, rsp_timeout, rsp_slverr}, rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    issue(16'h0020, 1'b0, 32'h0);
    pready = 1'b1; prdata = 32'h7777_0001;
    tick(); tick();
    pready = 1'b0;
    req_valid = 1'b1; req_addr = 16'h0031; req_write = 1'b1; req_wdata = 32'h5555_AAAA;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({rsp_valid, req_ready, psel, penable} !== 4'b1000 || rsp_rdata !== 32'h7777_0001 || {rsp_slverr, rsp_timeout} !== 2'b00) begin errors++; $display("FAIL bp_hold%0d: got v/rdy/sel/en=%b rdata=%h expected 1000 77770001", k, {rsp_valid, req_ready, psel, penable}, rsp_rdata); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0) begin errors++; $display("FAIL bp_idle: got rdy=%b rv=%b sel=%b expected 1 0 0", req_ready, rsp_valid, psel); end
    tick();
    req_valid = 1'b0;
    checks++; if ({psel, penable, pwrite} !== 3'b101 || paddr !== 16'h0031 || pwdata !== 32'h5555_AAAA) begin errors++; $display("FAIL bp_next_setup: got sel/en/wr=%b addr=%h data=%h expected 101 0031 5555aaaa", {psel, penable, pwrite}, paddr, pwdata); end
    pready = 1'b1;
    tick(); tick();
    pready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL bp_next_resp: got rv=%b rdata=%h expected 1 00000000", rsp_valid, rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_reset_during_access();
    issue(16'h0040, 1'b1, 32'hCAFE_0000);
    tick();
    checks++; if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL rsta_access: got sel/en=%b expected 11", {psel, penable}); end
    presetn = 1'b0;
    tick();
    checks++; if ({psel, penable, rsp_valid, req_ready} !== 4'b0000 || paddr !== 16'h0) begin errors++; $display("FAIL rsta_drop: got sel/en/rv/rdy=%b addr=%h expected 0000 0000", {psel, penable, rsp_valid, req_ready}, paddr); end
    pready = 1'b1;
    presetn = 1'b1;
    tick();
    pready = 1'b0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0) begin errors++; $display("FAIL rsta_release: got rdy=%b rv=%b sel=%b expected 1 0 0", req_ready, rsp_valid, psel); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsta_no_rsp: got %b expected 0", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_write_wait();
    test_read_fast();
    test_write_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_during_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
